// File: rtl/port_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : port_arbiter_if                                              |
// | Word strobes/data in, offer handshake out and error flags for the        |
// | three-port round-robin arbiter.                                          |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
interface port_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             check_l;
   logic             check_r;
   logic             check_s;
   logic [WIDTH-1:0] in_sig_left;
   logic [WIDTH-1:0] in_sig_right;
   logic [WIDTH-1:0] in_sig_self;
   logic [2:0]       full;
   logic [WIDTH-1:0] selected_sig;
   logic             sig_alert;
   logic [1:0]       s;
   logic             ctrl_ready;
   logic [2:0]       overflow;
   logic             timeout_err;
   logic             clear_err;

   // Environment side: receivers and node_controller.
   modport master (
      output check_l, check_r, check_s,
      output in_sig_left, in_sig_right, in_sig_self,
      output ctrl_ready, clear_err,
      input  full, selected_sig, sig_alert, s, overflow, timeout_err
   );

   // Arbiter side.
   modport slave (
      input  check_l, check_r, check_s,
      input  in_sig_left, in_sig_right, in_sig_self,
      input  ctrl_ready, clear_err,
      output full, selected_sig, sig_alert, s, overflow, timeout_err
   );
endinterface
`default_nettype wire

// File: rtl/port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : port_arbiter                                                  |
// | Buffers left/right/self instruction words in small FIFOs and offers one  |
// | at a time to node_controller, round-robin, over a valid/ready handshake. |
// | Option   : ARB_SELF_PRIORITY_EN - self FIFO always wins when non-empty.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module port_arbiter #(
   parameter int WIDTH   = 32,
   parameter int DEPTH   = 2,
   parameter int TIMEOUT = 16
) (
   input wire            clk,
   input wire            reset,
   port_arbiter_if.slave bus
);
   localparam int c_PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int c_CNT_W    = c_PTR_W + 1;
   localparam int c_TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int c_TMO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_OFFER = 1'b1
   } state_t;

   logic [2:0]            w_push;
   logic [2:0]            w_pop;
   logic [2:0]            w_full;
   logic [2:0]            w_ne;
   logic [2:0]            w_ovf_set;
   logic [2:0][WIDTH-1:0] w_din;
   logic [2:0][WIDTH-1:0] w_head;

   assign w_push = {bus.check_s, bus.check_r, bus.check_l};
   assign w_din  = {bus.in_sig_self, bus.in_sig_right, bus.in_sig_left};

   // Index 0 = left, 1 = right, 2 = self, matching the s encoding.
   for (genvar gi = 0; gi < 3; gi++) begin : g_fifo
      logic [WIDTH-1:0]   r_mem [DEPTH];
      logic [c_PTR_W-1:0] r_wptr;
      logic [c_PTR_W-1:0] r_rptr;
      logic [c_CNT_W-1:0] r_cnt;
      logic               w_wr;

      assign w_full[gi]    = (r_cnt == c_CNT_W'(DEPTH));
      assign w_ne[gi]      = (r_cnt != '0);
      assign w_wr          = w_push[gi] & (~w_full[gi] | w_pop[gi]);
      assign w_ovf_set[gi] = w_push[gi] & w_full[gi] & ~w_pop[gi];
      assign w_head[gi]    = r_mem[r_rptr];

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
         end else begin
            if (w_wr)
               r_wptr <= r_wptr + c_PTR_W'(1);
            if (w_pop[gi])
               r_rptr <= r_rptr + c_PTR_W'(1);
            r_cnt <= r_cnt + c_CNT_W'(w_wr) - c_CNT_W'(w_pop[gi]);
         end
      end

      always_ff @(posedge clk) begin
         if (w_wr)
            r_mem[r_wptr] <= w_din[gi];
      end
   end

   // First requester strictly after last in the cyclic order L->R->S->L.
   function automatic logic [1:0] f_rr(input logic [2:0] ne, input logic [1:0] last);
      logic [1:0] c0, c1, c2;
      case (last)
         2'd0:    begin c0 = 2'd1; c1 = 2'd2; c2 = 2'd0; end
         2'd1:    begin c0 = 2'd2; c1 = 2'd0; c2 = 2'd1; end
         default: begin c0 = 2'd0; c1 = 2'd1; c2 = 2'd2; end
      endcase
      if (ne[c0])      f_rr = c0;
      else if (ne[c1]) f_rr = c1;
      else             f_rr = c2;
   endfunction

   state_t             r_state, w_state_nx;
   logic [WIDTH-1:0]   r_sel, w_sel_nx;
   logic [1:0]         r_s, w_s_nx;
   logic [1:0]         r_last, w_last_nx;
   logic [1:0]         w_grant;
   logic               r_alert, w_alert_nx;
   logic [c_TMO_W-1:0] r_tcnt, w_tcnt_nx;
   logic               r_tmo_err, w_tmo_set;
   logic [2:0]         r_ovf;

`ifdef ARB_SELF_PRIORITY_EN
   assign w_grant = w_ne[2] ? 2'd2 : f_rr({1'b0, w_ne[1:0]}, r_last);
`else
   assign w_grant = f_rr(w_ne, r_last);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_sel     <= '0;
         r_s       <= 2'd0;
         r_last    <= 2'd2;
         r_alert   <= 1'b0;
         r_tcnt    <= '0;
         r_tmo_err <= 1'b0;
         r_ovf     <= 3'b000;
      end else begin
         r_state   <= w_state_nx;
         r_sel     <= w_sel_nx;
         r_s       <= w_s_nx;
         r_last    <= w_last_nx;
         r_alert   <= w_alert_nx;
         r_tcnt    <= w_tcnt_nx;
         // A set in the same cycle as clear_err wins.
         r_tmo_err <= (bus.clear_err ? 1'b0 : r_tmo_err) | w_tmo_set;
         r_ovf     <= (bus.clear_err ? 3'b000 : r_ovf) | w_ovf_set;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_sel_nx   = r_sel;
      w_s_nx     = r_s;
      w_last_nx  = r_last;
      w_alert_nx = r_alert;
      w_tcnt_nx  = r_tcnt;
      w_pop      = 3'b000;
      w_tmo_set  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_alert_nx = 1'b0;
            if (|w_ne) begin
               w_sel_nx   = w_head[w_grant];
               w_s_nx     = w_grant;
               w_alert_nx = 1'b1;
               w_tcnt_nx  = '0;
               w_state_nx = S_OFFER;
            end
         end
         S_OFFER: begin
            if (bus.ctrl_ready) begin
               w_pop      = 3'b001 << r_s;
               w_last_nx  = r_s;
               w_alert_nx = 1'b0;
               w_state_nx = S_IDLE;
            end else if ((TIMEOUT != 0) && (r_tcnt == c_TMO_W'(c_TMO_LAST))) begin
               w_pop      = 3'b001 << r_s;
               w_tmo_set  = 1'b1;
               w_last_nx  = r_s;
               w_alert_nx = 1'b0;
               w_state_nx = S_IDLE;
            end else begin
               w_tcnt_nx = r_tcnt + c_TMO_W'(1);
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
   end

   assign bus.full         = w_full;
   assign bus.selected_sig = r_sel;
   assign bus.sig_alert    = r_alert;
   assign bus.s            = r_s;
   assign bus.overflow     = r_ovf;
   assign bus.timeout_err  = r_tmo_err;
endmodule
`default_nettype wire

// File: tb/tb_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_port_arbiter                                               |
// | Directed self-checking bench for port_arbiter (WIDTH 32, DEPTH 2,        |
// | TIMEOUT 16). Honours ARB_SELF_PRIORITY_EN for the arbitration order.     |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_port_arbiter;
   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   port_arbiter_if #(.WIDTH(32)) bus ();

   port_arbiter #(
      .WIDTH   (32),
      .DEPTH   (2),
      .TIMEOUT (16)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and return at the following falling edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.check_l      = 1'b0;
      bus.check_r      = 1'b0;
      bus.check_s      = 1'b0;
      bus.in_sig_left  = '0;
      bus.in_sig_right = '0;
      bus.in_sig_self  = '0;
      bus.ctrl_ready   = 1'b0;
      bus.clear_err    = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   logic [31:0] exp_word [3];
   logic [1:0]  exp_src  [3];
   int          cycles;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset values, sampled while reset is held.
      reset = 1'b1;
      idle_inputs();
      @(negedge clk);
      @(negedge clk);
      chk("rst_alert", bus.sig_alert, 1'b0);
      chk("rst_sel", bus.selected_sig, 32'h0);
      chk("rst_s", bus.s, 2'b00);
      chk("rst_ovf", bus.overflow, 3'b000);
      chk("rst_tmo", bus.timeout_err, 1'b0);
      chk("rst_full", bus.full, 3'b000);
      reset = 1'b0;

      // Single left word: offer two edges after the push, high one cycle.
      bus.ctrl_ready  = 1'b1;
      bus.check_l     = 1'b1;
      bus.in_sig_left = 32'hA5A5_0001;
      tick();
      bus.check_l = 1'b0;
      chk("lat_edge1_alert", bus.sig_alert, 1'b0);
      tick();
      chk("lat_alert", bus.sig_alert, 1'b1);
      chk("lat_s", bus.s, 2'b00);
      chk("lat_sel", bus.selected_sig, 32'hA5A5_0001);
      tick();
      chk("lat_one_cycle", bus.sig_alert, 1'b0);

      // Three ports in the same cycle.
      do_reset();
`ifdef ARB_SELF_PRIORITY_EN
      exp_word = '{32'h33, 32'h11, 32'h22};
      exp_src  = '{2'd2, 2'd0, 2'd1};
`else
      exp_word = '{32'h11, 32'h22, 32'h33};
      exp_src  = '{2'd0, 2'd1, 2'd2};
`endif
      bus.ctrl_ready   = 1'b1;
      bus.check_l      = 1'b1;
      bus.check_r      = 1'b1;
      bus.check_s      = 1'b1;
      bus.in_sig_left  = 32'h11;
      bus.in_sig_right = 32'h22;
      bus.in_sig_self  = 32'h33;
      tick();
      bus.check_l = 1'b0;
      bus.check_r = 1'b0;
      bus.check_s = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk($sformatf("rr%0d_alert", i), bus.sig_alert, 1'b1);
         chk($sformatf("rr%0d_sel", i), bus.selected_sig, exp_word[i]);
         chk($sformatf("rr%0d_s", i), bus.s, exp_src[i]);
         tick();
         chk($sformatf("rr%0d_bubble", i), bus.sig_alert, 1'b0);
      end

      // Right FIFO overflow with ctrl_ready low, then clear.
      do_reset();
      bus.check_r      = 1'b1;
      bus.in_sig_right = 32'h100;
      tick();
      chk("ovf_full_after1", bus.full, 3'b000);
      bus.in_sig_right = 32'h101;
      tick();
      chk("ovf_full_after2", bus.full, 3'b010);
      bus.in_sig_right = 32'h102;
      tick();
      bus.check_r = 1'b0;
      chk("ovf_flag", bus.overflow, 3'b010);
      chk("ovf_still_full", bus.full, 3'b010);
      chk("ovf_offer_head", bus.selected_sig, 32'h100);
      bus.clear_err = 1'b1;
      tick();
      bus.clear_err = 1'b0;
      chk("ovf_cleared", bus.overflow, 3'b000);

      // Full FIFO: push and handshake pop in the same cycle.
      bus.ctrl_ready   = 1'b1;
      bus.check_r      = 1'b1;
      bus.in_sig_right = 32'h103;
      tick();
      bus.check_r = 1'b0;
      chk("pp_full", bus.full, 3'b010);
      chk("pp_no_ovf", bus.overflow, 3'b000);
      chk("pp_alert_low", bus.sig_alert, 1'b0);
      tick();
      chk("pp_next_word", bus.selected_sig, 32'h101);
      tick();
      tick();
      chk("pp_pushed_word", bus.selected_sig, 32'h103);
      tick();
      chk("pp_drained", bus.full, 3'b000);

      // Self word left unaccepted: discarded after 16 offer cycles.
      do_reset();
      bus.check_s     = 1'b1;
      bus.in_sig_self = 32'h33;
      tick();
      bus.check_s = 1'b0;
      tick();
      chk("tmo_s", bus.s, 2'b10);
      cycles = 0;
      while (bus.sig_alert === 1'b1 && cycles < 40) begin
         cycles++;
         tick();
      end
      chk("tmo_cycles", cycles, 16);
      chk("tmo_err", bus.timeout_err, 1'b1);
      tick();
      chk("tmo_fifo_empty", bus.sig_alert, 1'b0);
      bus.clear_err = 1'b1;
      tick();
      bus.clear_err = 1'b0;
      chk("tmo_cleared", bus.timeout_err, 1'b0);

      // Accept in the last offer cycle before the timeout.
      bus.check_s     = 1'b1;
      bus.in_sig_self = 32'h34;
      tick();
      bus.check_s = 1'b0;
      tick();
      for (int i = 0; i < 15; i++) tick();
      chk("tmo_last_alert", bus.sig_alert, 1'b1);
      bus.ctrl_ready = 1'b1;
      tick();
      bus.ctrl_ready = 1'b0;
      chk("tmo_late_accept", bus.sig_alert, 1'b0);
      chk("tmo_late_noerr", bus.timeout_err, 1'b0);
      tick();
      chk("tmo_late_idle", bus.sig_alert, 1'b0);

      // Asynchronous reset in the middle of an offer.
      do_reset();
      bus.check_l      = 1'b1;
      bus.check_r      = 1'b1;
      bus.in_sig_left  = 32'h55;
      bus.in_sig_right = 32'h66;
      tick();
      bus.check_l = 1'b0;
      bus.check_r = 1'b0;
      tick();
      chk("mid_alert", bus.sig_alert, 1'b1);
      #2 reset = 1'b1;
      #1 chk("mid_async_alert", bus.sig_alert, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      chk("mid_full", bus.full, 3'b000);
      tick();
      chk("mid_empty", bus.sig_alert, 1'b0);
      bus.check_l      = 1'b1;
      bus.check_r      = 1'b1;
      bus.in_sig_left  = 32'h88;
      bus.in_sig_right = 32'h77;
      tick();
      bus.check_l = 1'b0;
      bus.check_r = 1'b0;
      tick();
      chk("mid_first_s", bus.s, 2'b00);
      chk("mid_first_sel", bus.selected_sig, 32'h88);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
